// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the crossbar allocator.
// Holds the per-output FSM state encoding and the index-width helper.
package crossbar_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/crossbar_alloc_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr, searching upward
// modulo N. Ports: req (N) and ptr (AW) in; one-hot gnt (N) and idx (AW) out.
module rr_arbiter
  import crossbar_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [AW-1:0] idx
);

  logic [AW-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = AW'((int'(ptr) + k) % N);
      if (req[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/crossbar_alloc.sv
// Crossbar allocator: per-output IDLE/BUSY FSM with round-robin packet grant.
// Ports: clk, nreset; req_valid/req_dest/req_last/req_ready per input;
// sel (N*N one-hot selects), out_valid/out_last/out_ready per output.
module crossbar_alloc
  import crossbar_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = idx_w(N)
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    req_valid,
  input  logic [N*AW-1:0] req_dest,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  output logic [N*N-1:0]  sel,
  output logic [N-1:0]    out_valid,
  output logic [N-1:0]    out_last,
  input  logic [N-1:0]    out_ready
);

  state_t        state_q [N];
  state_t        state_d [N];
  logic [AW-1:0] owner_q [N];
  logic [AW-1:0] owner_d [N];
  logic [AW-1:0] ptr_q   [N];
  logic [AW-1:0] ptr_d   [N];

  logic [AW-1:0] dest    [N];
  logic [N-1:0]  cand    [N];
  logic [N-1:0]  gnt     [N];
  logic [AW-1:0] win     [N];
  logic [N-1:0]  hit;

  always_comb begin
    for (int j = 0; j < N; j++) begin
      dest[j] = req_dest[j*AW +: AW];
    end
  end

  always_comb begin
    for (int o = 0; o < N; o++) begin
      for (int j = 0; j < N; j++) begin
        cand[o][j] = req_valid[j] && (dest[j] == AW'(o));
      end
    end
  end

  for (genvar o = 0; o < N; o++) begin : g_out
    rr_arbiter #(
      .N  (N),
      .AW (AW)
    ) u_arb (
      .req (cand[o]),
      .ptr (ptr_q[o]),
      .gnt (gnt[o]),
      .idx (win[o])
    );

    assign hit[o] = |gnt[o];

    hold_dest: assert property (
      @(posedge clk) disable iff (!nreset)
      (state_q[o] == BUSY) |-> (dest[owner_q[o]] == AW'(o))
    ) else $error("req_dest of owner changed while output %0d busy", o);
  end

  // Outputs depend on state and upstream signals only; out_ready
  // reaches nothing but req_ready.
  always_comb begin
    sel       = '0;
    out_valid = '0;
    out_last  = '0;
    req_ready = '0;
    for (int o = 0; o < N; o++) begin
      if (state_q[o] == BUSY) begin
        sel[o*N +: N]         = N'(1) << owner_q[o];
        out_valid[o]          = req_valid[owner_q[o]];
        out_last[o]           = req_last[owner_q[o]];
        req_ready[owner_q[o]] = req_ready[owner_q[o]] | out_ready[o];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < N; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      unique case (state_q[o])
        IDLE: begin
          if (hit[o]) begin
            state_d[o] = BUSY;
            owner_d[o] = win[o];
          end
        end
        BUSY: begin
          if (req_valid[owner_q[o]] && out_ready[o]
              && req_last[owner_q[o]]) begin
            state_d[o] = IDLE;
            ptr_d[o]   = (owner_q[o] == AW'(N - 1))
                         ? '0 : owner_q[o] + 1'b1;
          end
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int o = 0; o < N; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < N; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

endmodule
